// File: rtl/exe_pkg.sv
// Shared types and constants for the execution issue/write-back unit.
//   OpNop / OpDebugPrint : opcodes that complete without a RAM write-back
//   exe_state_t          : issue-unit control states
//   exe_entry_t          : in-flight tag {op, dest, squash} held in the tag FIFO
package exe_pkg;

  localparam int unsigned ExeOpW   = 6;
  localparam int unsigned ExeAddrW = 16;

  localparam logic [ExeOpW-1:0] OpNop        = 6'h00;
  localparam logic [ExeOpW-1:0] OpDebugPrint = 6'h3F;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } exe_state_t;

  typedef struct packed {
    logic [ExeOpW-1:0]   op;
    logic [ExeAddrW-1:0] dest;
    logic                squash;
  } exe_entry_t;

endpackage

// File: rtl/exe_tag_fifo.sv
// In-order tag FIFO for outstanding ALU operations.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   push_i         : append push_entry_i at the tail (ignored when full and not popping)
//   pop_i          : drop the head entry (ignored when empty)
//   squash_all_i   : set squash on every entry currently held
//   head_o         : oldest entry
//   entries_o      : raw storage, qualified by valid_o, for dependency compares
//   count_o        : occupancy; full_o / empty_o derived from it
// Depth must be a power of two so the pointers wrap naturally.
module exe_tag_fifo import exe_pkg::*; #(
  parameter int unsigned Depth = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push_i,
  input  exe_entry_t                     push_entry_i,
  input  logic                           pop_i,
  input  logic                           squash_all_i,
  output exe_entry_t                     head_o,
  output exe_entry_t [Depth-1:0]         entries_o,
  output logic [Depth-1:0]               valid_o,
  output logic [$clog2(Depth+1)-1:0]     count_o,
  output logic                           full_o,
  output logic                           empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);

  exe_entry_t [Depth-1:0] mem_q, mem_d;
  logic [PtrW-1:0]        rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]        count_q;
  logic [PtrW-1:0]        offset;
  logic                   do_push, do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CntW'(Depth));
  assign do_pop    = pop_i & ~empty_o;
  assign do_push   = push_i & (~full_o | do_pop);
  assign head_o    = mem_q[rd_ptr_q];
  assign entries_o = mem_q;
  assign count_o   = count_q;

  // Slot i is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    valid_o = '0;
    offset  = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      offset     = PtrW'(i) - rd_ptr_q;
      valid_o[i] = ({1'b0, offset} < count_q);
    end
  end

  // Squash marks stored entries first; a same-cycle push is never squashed.
  always_comb begin
    mem_d = mem_q;
    if (squash_all_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        if (valid_o[i]) mem_d[i].squash = 1'b1;
      end
    end
    if (do_push) mem_d[wr_ptr_q] = push_entry_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_q + PtrW'(do_pop);
      wr_ptr_q <= wr_ptr_q + PtrW'(do_push);
      count_q  <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/exe_issue_unit.sv
// Execution issue/write-back unit between decode and the ALU, with up to DEPTH ops in flight.
// Ops complete in order through a tag FIFO; a taken branch at the head squashes everything
// younger, and those entries are then drained without writing back.
//   Clock, Reset                 : clock, asynchronous active-high reset
//   iDecValid / oDecReady        : decode handshake
//   iOperation, iSource0/1       : op and operand rows (channel 0 in MSBs)
//   iSrcAddr0/1                  : operand addresses, used only for RAW stalls
//   iDestination                 : write-back address or jump target
//   oALUOperation, oALUSourceA/B : registered op/operands (A = iSource1, B = iSource0)
//   oTriggerALU                  : one-cycle start pulse, the cycle after issue
//   iALUResult, iALUOutputReady  : result of the FIFO head
//   iBranchTaken/NotTaken        : qualify the completing head as a branch
//   oJumpFlag, oJumpIp           : fetch redirect (combinational)
//   oRAMWrite*                   : write-back (combinational, data = iALUResult)
//   oBusy, oOutstanding          : FIFO full or flushing / occupancy
//   oLastDestination             : destination of the most recent issue
//   oProtocolErr                 : sticky, result presented with nothing in flight
// Optional: define EXE_HAZARD_EN to stall issue while an operand address matches a live,
// non-squashed destination in the FIFO.
module exe_issue_unit import exe_pkg::*; #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned OP_W       = ExeOpW,
  parameter int unsigned DADDR_W    = ExeAddrW,
  parameter int unsigned ROM_ADDR_W = 16,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          iDecValid,
  output logic                          oDecReady,
  input  logic [OP_W-1:0]               iOperation,
  input  logic [CHANNELS*WIDTH-1:0]     iSource0,
  input  logic [CHANNELS*WIDTH-1:0]     iSource1,
  input  logic [DADDR_W-1:0]            iSrcAddr0,
  input  logic [DADDR_W-1:0]            iSrcAddr1,
  input  logic [DADDR_W-1:0]            iDestination,
  output logic [OP_W-1:0]               oALUOperation,
  output logic [CHANNELS*WIDTH-1:0]     oALUSourceA,
  output logic [CHANNELS*WIDTH-1:0]     oALUSourceB,
  output logic                          oTriggerALU,
  input  logic [CHANNELS*WIDTH-1:0]     iALUResult,
  input  logic                          iALUOutputReady,
  input  logic                          iBranchTaken,
  input  logic                          iBranchNotTaken,
  output logic                          oJumpFlag,
  output logic [ROM_ADDR_W-1:0]         oJumpIp,
  output logic                          oRAMWriteEnable,
  output logic [DADDR_W-1:0]            oRAMWriteAddress,
  output logic [CHANNELS*WIDTH-1:0]     oRAMWriteData,
  output logic                          oBusy,
  output logic [DADDR_W-1:0]            oLastDestination,
  output logic [$clog2(DEPTH+1)-1:0]    oOutstanding,
  output logic                          oProtocolErr
);

  localparam int unsigned RowW = CHANNELS * WIDTH;
  localparam int unsigned CntW = $clog2(DEPTH+1);

  exe_state_t             state_q, state_d;
  exe_entry_t             head, push_entry;
  exe_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]       valid;
  logic [CntW-1:0]        count, count_next;
  logic                   full, empty;
  logic                   issue, complete, jump, hazard;

  logic [OP_W-1:0]        alu_op_q;
  logic [RowW-1:0]        src_a_q, src_b_q;
  logic                   trigger_q;
  logic [DADDR_W-1:0]     last_dest_q;
  logic                   perr_q;

  exe_tag_fifo #(
    .Depth (DEPTH)
  ) u_tag_fifo (
    .clk_i        (Clock),
    .rst_i        (Reset),
    .push_i       (issue),
    .push_entry_i (push_entry),
    .pop_i        (complete),
    .squash_all_i (jump),
    .head_o       (head),
    .entries_o    (entries),
    .valid_o      (valid),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty)
  );

`ifdef EXE_HAZARD_EN
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && !entries[i].squash &&
          (entries[i].dest == iSrcAddr0 || entries[i].dest == iSrcAddr1)) begin
        hazard = 1'b1;
      end
    end
  end
`else
  logic unused_hazard_inputs;
  assign hazard               = 1'b0;
  assign unused_hazard_inputs = ^{iSrcAddr0, iSrcAddr1, entries, valid};
`endif

  assign push_entry.op     = iOperation;
  assign push_entry.dest   = iDestination;
  assign push_entry.squash = 1'b0;

  assign complete = iALUOutputReady & ~empty;
  assign jump     = complete & iBranchTaken & ~head.squash;

  // Blocking issue during a jump keeps the new op out of the squash that edge.
  assign oDecReady = ~Reset & ~full & (state_q != StFlush) & ~jump & ~hazard;
  assign issue     = iDecValid & oDecReady;

  assign oRAMWriteEnable  = complete & ~head.squash & ~iBranchTaken & ~iBranchNotTaken &
                            (head.op != OpNop) & (head.op != OpDebugPrint);
  assign oRAMWriteAddress = head.dest;
  assign oRAMWriteData    = iALUResult;
  assign oJumpFlag        = jump;
  assign oJumpIp          = head.dest[ROM_ADDR_W-1:0];

  assign oBusy            = full | (state_q == StFlush);
  assign oOutstanding     = count;
  assign oALUOperation    = alu_op_q;
  assign oALUSourceA      = src_a_q;
  assign oALUSourceB      = src_b_q;
  assign oTriggerALU      = trigger_q;
  assign oLastDestination = last_dest_q;
  assign oProtocolErr     = perr_q;

  assign count_next = count + CntW'(issue) - CntW'(complete);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (issue) state_d = StRun;
      StRun: begin
        if (jump) begin
          state_d = (count_next != '0) ? StFlush : StIdle;
        end else if (count_next == '0) begin
          state_d = StIdle;
        end
      end
      StFlush: if (count_next == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      alu_op_q    <= '0;
      src_a_q     <= '0;
      src_b_q     <= '0;
      trigger_q   <= 1'b0;
      last_dest_q <= '0;
      perr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      trigger_q <= issue;
      if (issue) begin
        alu_op_q    <= iOperation;
        src_a_q     <= iSource1;
        src_b_q     <= iSource0;
        last_dest_q <= iDestination;
      end
      if (iALUOutputReady && empty) perr_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_exe_issue_unit.sv
// Self-checking bench for exe_issue_unit: directed scenarios plus randomized traffic checked
// against a queue-based reference model, with a scoreboard monitor for write-backs and jumps.
module tb_exe_issue_unit;
  import exe_pkg::*;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned CHANNELS   = 3;
  localparam int unsigned OP_W       = 6;
  localparam int unsigned DADDR_W    = 16;
  localparam int unsigned ROM_ADDR_W = 16;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned RowW       = WIDTH * CHANNELS;
  localparam int unsigned CntW       = $clog2(DEPTH + 1);

  localparam logic [OP_W-1:0] OpAdd = 6'h01;
  localparam logic [OP_W-1:0] OpJmp = 6'h20;

  logic                  Clock, Reset;
  logic                  iDecValid, oDecReady;
  logic [OP_W-1:0]       iOperation, oALUOperation;
  logic [RowW-1:0]       iSource0, iSource1, oALUSourceA, oALUSourceB, iALUResult, oRAMWriteData;
  logic [DADDR_W-1:0]    iSrcAddr0, iSrcAddr1, iDestination, oRAMWriteAddress, oLastDestination;
  logic                  oTriggerALU, iALUOutputReady, iBranchTaken, iBranchNotTaken;
  logic                  oJumpFlag, oRAMWriteEnable, oBusy, oProtocolErr;
  logic [ROM_ADDR_W-1:0] oJumpIp;
  logic [CntW-1:0]       oOutstanding;

  exe_issue_unit #(
    .WIDTH      (WIDTH),
    .CHANNELS   (CHANNELS),
    .OP_W       (OP_W),
    .DADDR_W    (DADDR_W),
    .ROM_ADDR_W (ROM_ADDR_W),
    .DEPTH      (DEPTH)
  ) dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .iDecValid        (iDecValid),
    .oDecReady        (oDecReady),
    .iOperation       (iOperation),
    .iSource0         (iSource0),
    .iSource1         (iSource1),
    .iSrcAddr0        (iSrcAddr0),
    .iSrcAddr1        (iSrcAddr1),
    .iDestination     (iDestination),
    .oALUOperation    (oALUOperation),
    .oALUSourceA      (oALUSourceA),
    .oALUSourceB      (oALUSourceB),
    .oTriggerALU      (oTriggerALU),
    .iALUResult       (iALUResult),
    .iALUOutputReady  (iALUOutputReady),
    .iBranchTaken     (iBranchTaken),
    .iBranchNotTaken  (iBranchNotTaken),
    .oJumpFlag        (oJumpFlag),
    .oJumpIp          (oJumpIp),
    .oRAMWriteEnable  (oRAMWriteEnable),
    .oRAMWriteAddress (oRAMWriteAddress),
    .oRAMWriteData    (oRAMWriteData),
    .oBusy            (oBusy),
    .oLastDestination (oLastDestination),
    .oOutstanding     (oOutstanding),
    .oProtocolErr     (oProtocolErr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [OP_W-1:0]    op;
    logic [DADDR_W-1:0] dest;
    bit                 squash;
  } mentry_t;

  typedef struct {
    bit                 is_jump;
    logic [DADDR_W-1:0] addr;
    logic [RowW-1:0]    data;
  } exp_t;

  mentry_t            mq[$];     // ops in flight, oldest first
  exp_t               exp_q[$];  // expected write-back / jump events
  int                 checks = 0;
  int                 errors = 0;
  bit                 m_flush, m_perr, exp_trig;
  logic [OP_W-1:0]    exp_op;
  logic [RowW-1:0]    exp_a, exp_b;
  logic [DADDR_W-1:0] m_last;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [RowW-1:0] rand_row();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Scoreboard monitor: every write-back or jump the DUT presents must match the next event.
  always @(negedge Clock) begin
    exp_t e;
    if (!Reset && (oRAMWriteEnable || oJumpFlag)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: we=%0b jump=%0b addr=%0h expected none",
                 oRAMWriteEnable, oJumpFlag, oRAMWriteAddress);
      end else begin
        e = exp_q.pop_front();
        chk("event_is_jump", oJumpFlag, e.is_jump);
        chk("event_is_write", oRAMWriteEnable, !e.is_jump);
        if (e.is_jump) begin
          chk("jump_ip", oJumpIp, e.addr[ROM_ADDR_W-1:0]);
        end else begin
          chk("wb_addr", oRAMWriteAddress, e.addr);
          chk("wb_data", oRAMWriteData, e.data);
        end
      end
    end
  end

  // One clock of stimulus; the model predicts this cycle's outputs, then advances past the edge.
  task automatic step(input bit dv, input logic [OP_W-1:0] op, input logic [DADDR_W-1:0] dest,
                      input bit rdy, input bit bt = 1'b0, input bit bnt = 1'b0,
                      input logic [DADDR_W-1:0] sa0 = 16'hFFFF,
                      input logic [DADDR_W-1:0] sa1 = 16'hFFFF);
    bit              complete, jump, ready, issue, hz;
    logic [RowW-1:0] res;
    exp_t            e;
    mentry_t         n;
    @(posedge Clock);
    #1;
    chk("trigger", oTriggerALU, exp_trig);
    if (exp_trig) begin
      chk("alu_op", oALUOperation, exp_op);
      chk("alu_src_a", oALUSourceA, exp_a);
      chk("alu_src_b", oALUSourceB, exp_b);
    end
    res             = rand_row();
    iDecValid       = dv;
    iOperation      = op;
    iDestination    = dest;
    iSource0        = rand_row();
    iSource1        = rand_row();
    iSrcAddr0       = sa0;
    iSrcAddr1       = sa1;
    iALUResult      = res;
    iALUOutputReady = rdy;
    iBranchTaken    = bt;
    iBranchNotTaken = bnt;

    complete = rdy && (mq.size() > 0);
    jump     = complete && bt && !mq[0].squash;
    hz       = 1'b0;
`ifdef EXE_HAZARD_EN
    foreach (mq[i]) if (!mq[i].squash && (mq[i].dest == sa0 || mq[i].dest == sa1)) hz = 1'b1;
`endif
    ready = (mq.size() < DEPTH) && !m_flush && !jump && !hz;
    issue = dv && ready;
    if (complete && !mq[0].squash && !bt && !bnt && mq[0].op != OpNop && mq[0].op != OpDebugPrint)
    begin
      e.is_jump = 1'b0;
      e.addr    = mq[0].dest;
      e.data    = res;
      exp_q.push_back(e);
    end
    if (jump) begin
      e.is_jump = 1'b1;
      e.addr    = mq[0].dest;
      e.data    = res;
      exp_q.push_back(e);
    end
    #2;
    chk("dec_ready", oDecReady, ready);
    chk("outstanding", oOutstanding, mq.size());
    chk("busy", oBusy, (mq.size() == DEPTH) || m_flush);
    chk("protocol_err", oProtocolErr, m_perr);
    chk("last_dest", oLastDestination, m_last);

    if (rdy && mq.size() == 0) m_perr = 1'b1;
    if (complete) begin
      void'(mq.pop_front());
      if (jump) begin
        foreach (mq[i]) mq[i].squash = 1'b1;
        if (mq.size() > 0) m_flush = 1'b1;
      end
    end
    if (issue) begin
      n.op     = op;
      n.dest   = dest;
      n.squash = 1'b0;
      mq.push_back(n);
      m_last = dest;
      exp_op = op;
      exp_a  = iSource1;
      exp_b  = iSource0;
    end
    exp_trig = issue;
    if (mq.size() == 0) m_flush = 1'b0;
  endtask

  task automatic idle_inputs();
    iDecValid       = 1'b0;
    iOperation      = '0;
    iDestination    = '0;
    iSource0        = '0;
    iSource1        = '0;
    iSrcAddr0       = '1;
    iSrcAddr1       = '1;
    iALUResult      = '0;
    iALUOutputReady = 1'b0;
    iBranchTaken    = 1'b0;
    iBranchNotTaken = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, oDecReady, 1'b0);
    chk({tag, "_outstanding"}, oOutstanding, '0);
    chk({tag, "_trigger"}, oTriggerALU, 1'b0);
    chk({tag, "_we"}, oRAMWriteEnable, 1'b0);
    chk({tag, "_jump"}, oJumpFlag, 1'b0);
    chk({tag, "_busy"}, oBusy, 1'b0);
    chk({tag, "_perr"}, oProtocolErr, 1'b0);
    chk({tag, "_alu_op"}, oALUOperation, '0);
    chk({tag, "_last_dest"}, oLastDestination, '0);
  endtask

  task automatic clear_model();
    mq.delete();
    exp_q.delete();
    m_flush  = 1'b0;
    m_perr   = 1'b0;
    exp_trig = 1'b0;
    m_last   = '0;
    exp_op   = '0;
    exp_a    = '0;
    exp_b    = '0;
  endtask

  task automatic do_reset();
    @(posedge Clock);
    #1;
    idle_inputs();
    #1;
    Reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge Clock);
    #2;
    Reset = 1'b0;
    clear_model();
  endtask

  task automatic drain();
    for (int k = 0; k < 3 * DEPTH && mq.size() > 0; k++) step(1'b0, OpAdd, '0, 1'b1);
    chk("drained", mq.size(), 0);
  endtask

  initial begin
    bit                 dv, rdy, bt, bnt;
    logic [OP_W-1:0]    op;
    logic [DADDR_W-1:0] dest;
    int unsigned        r;

    idle_inputs();
    clear_model();
    Reset = 1'b1;
    #3;
    check_reset_outputs("reset");
    #10;
    Reset = 1'b0;

    // Single ADD: trigger next cycle, result two cycles later writes 0x10.
    step(1'b1, OpAdd, 16'h0010, 1'b0);
    step(1'b0, OpAdd, '0, 1'b0);
    step(1'b0, OpAdd, '0, 1'b0);
    step(1'b0, OpAdd, '0, 1'b1);
    step(1'b0, OpAdd, '0, 1'b0);

    // Fill to DEPTH, try issue at full, then pop+issue together.
    for (int i = 0; i < DEPTH; i++) step(1'b1, OpAdd, 16'h0100 + 16'(i), 1'b0);
    step(1'b1, OpAdd, 16'h01FF, 1'b0);
    step(1'b1, OpAdd, 16'h0104, 1'b1);
    drain();

    // Taken branch at head with two younger ops; issue attempts during flush are refused.
    step(1'b1, OpJmp, 16'h0042, 1'b0);
    step(1'b1, OpAdd, 16'h0050, 1'b0);
    step(1'b1, OpAdd, 16'h0051, 1'b0);
    step(1'b1, OpAdd, 16'h0052, 1'b1, 1'b1);
    step(1'b1, OpAdd, 16'h0053, 1'b1);
    step(1'b1, OpAdd, 16'h0054, 1'b1);
    step(1'b0, OpAdd, '0, 1'b0);
    drain();

    // NOP and DEBUG_PRINT write nothing; untaken branch neither writes nor jumps.
    step(1'b1, OpNop, 16'h0060, 1'b0);
    step(1'b1, OpDebugPrint, 16'h0061, 1'b0);
    step(1'b1, OpJmp, 16'h0062, 1'b0);
    step(1'b0, OpAdd, '0, 1'b1);
    step(1'b0, OpAdd, '0, 1'b1);
    step(1'b0, OpAdd, '0, 1'b1, 1'b0, 1'b1);

    // Result with nothing in flight: ignored, error flag sticks.
    step(1'b0, OpAdd, '0, 1'b1);
    step(1'b0, OpAdd, '0, 1'b0);
    step(1'b1, OpAdd, 16'h0070, 1'b0);
    step(1'b0, OpAdd, '0, 1'b0);

    // Reset with ops in flight clears everything.
    step(1'b1, OpAdd, 16'h0071, 1'b0);
    do_reset();
    step(1'b0, OpAdd, '0, 1'b0);

`ifdef EXE_HAZARD_EN
    step(1'b1, OpAdd, 16'h0020, 1'b0);
    step(1'b1, OpAdd, 16'h0021, 1'b0, 1'b0, 1'b0, 16'h0020);
    step(1'b1, OpAdd, 16'h0021, 1'b0, 1'b0, 1'b0, 16'h0020);
    step(1'b1, OpAdd, 16'h0021, 1'b1, 1'b0, 1'b0, 16'h0020);
    step(1'b1, OpAdd, 16'h0021, 1'b0, 1'b0, 1'b0, 16'h0020);
    drain();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      dv   = ($urandom_range(0, 2) != 0);
      r    = $urandom_range(0, 7);
      op   = (r == 0) ? OpNop : (r == 1) ? OpDebugPrint : (r == 2) ? OpJmp : OpAdd;
      dest = 16'($urandom_range(0, 7));
      rdy  = (mq.size() > 0) && ($urandom_range(0, 2) == 0);
      r    = $urandom_range(0, 7);
      bt   = rdy && (r == 0);
      bnt  = rdy && (r == 1);
      step(dv, op, dest, rdy, bt, bnt, 16'($urandom_range(0, 7)), 16'($urandom_range(0, 7)));
    end
    drain();
    step(1'b0, OpAdd, '0, 1'b0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
